// File: rtl/arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
// Optional ARB_FIXED_PRIO_EN (see rr_select) gives client 0 absolute priority.
package arb_pkg;

  localparam int ARB_AW = 24;
  localparam int ARB_DW = 16;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Issue  = 2'd1,
    RdWait = 2'd2,
    Ack    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first requester after i_last, with wrap.
// With ARB_FIXED_PRIO_EN defined, client 0 always wins and the rest rotate.
module rr_select #(
  parameter int N  = 4,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [LW-1:0] o_grant,
  output logic          o_any
);

  logic [N-1:0] w_req;
  logic         w_found_hi;

  always_comb begin
    o_grant    = '0;
    o_any      = |i_req;
    w_found_hi = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    w_req = i_req & {{(N-1){1'b1}}, 1'b0};
`else
    w_req = i_req;
`endif
    // Descending scans so the lowest qualifying index is the one left in o_grant.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req[i] && (i > int'(i_last))) begin
        o_grant    = LW'(i);
        w_found_hi = 1'b1;
      end
    end
    if (!w_found_hi) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (w_req[i]) begin
          o_grant = LW'(i);
        end
      end
    end
`ifdef ARB_FIXED_PRIO_EN
    if (i_req[0]) begin
      o_grant = '0;
    end
`endif
  end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter forwarding one client transfer at a time to a single memory port.
// Build option ARB_FIXED_PRIO_EN: client 0 (display refresh reader) always has priority.
module arbiter_rr
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic [N-1:0]  cli_req,
  output logic [N-1:0]  cli_ack,
  input  logic [N*AW-1:0] cli_addr,
  input  logic [N*DW-1:0] cli_data,
  input  logic [N-1:0]  cli_wr,
  output logic [DW-1:0] cli_rdata,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    r_state;
  logic [LW-1:0] r_last;
  logic [N-1:0]  r_ack;
  logic [DW-1:0] r_rdata;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_mem_wr;

  logic [LW-1:0] w_gnt;
  logic          w_any;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_wr;
  logic [N-1:0]  w_onehot;

  rr_select #(
    .N  (N),
    .LW (LW)
  ) u_sel (
    .i_req   (cli_req),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_any   (w_any)
  );

  always_comb begin
    w_addr   = '0;
    w_data   = '0;
    w_wr     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == LW'(i)) begin
        w_addr = cli_addr[i*AW +: AW];
        w_data = cli_data[i*DW +: DW];
        w_wr   = cli_wr[i];
      end
      w_onehot[i] = (r_last == LW'(i));
    end
  end

  // r_last doubles as the index of the client currently being served.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= Idle;
      r_last     <= LW'(N - 1);
      r_ack      <= '0;
      r_rdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
    end else begin
      case (r_state)
        Idle: begin
          if (w_any) begin
            r_mem_addr <= w_addr;
            r_mem_data <= w_data;
            r_mem_wr   <= w_wr;
            r_mem_req  <= 1'b1;
            r_last     <= w_gnt;
            r_state    <= Issue;
          end
        end
        Issue: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_mem_wr) begin
              r_ack   <= w_onehot;
              r_state <= Ack;
            end else if (mem_rvalid) begin
              r_rdata <= mem_rdata;
              r_ack   <= w_onehot;
              r_state <= Ack;
            end else begin
              r_state <= RdWait;
            end
          end
        end
        RdWait: begin
          if (mem_rvalid) begin
            r_rdata <= mem_rdata;
            r_ack   <= w_onehot;
            r_state <= Ack;
          end
        end
        Ack: begin
          r_ack   <= '0;
          r_state <= Idle;
        end
        default: begin
          r_ack   <= '0;
          r_state <= Idle;
        end
      endcase
    end
  end

  assign cli_ack   = r_ack;
  assign cli_rdata = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed self-checking bench for arbiter_rr (N=4) with a simple memory responder.
module tb_arbiter_rr;

  logic          clkSYS;
  logic          n_reset;
  logic [3:0]    cli_req;
  logic [3:0]    cli_ack;
  logic [95:0]   cli_addr;
  logic [63:0]   cli_data;
  logic [3:0]    cli_wr;
  logic [15:0]   cli_rdata;
  logic          mem_req;
  logic          mem_ack;
  logic [23:0]   mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wr;
  logic [15:0]   mem_rdata;
  logic          mem_rvalid;

  int n_checks;
  int n_errors;
  int cyc;
  int rearm_dly;
  int rearm [4];
  int ack_log [$];
  int ack_cyc [$];
  logic [15:0] ack_rd [$];
  logic [23:0] obs_addr;
  logic [15:0] obs_data;
  logic        obs_wr;
  logic [23:0] addr_tab [4];

  arbiter_rr #(.N(4), .AW(24), .DW(16)) dut (
    .clkSYS     (clkSYS),
    .n_reset    (n_reset),
    .cli_req    (cli_req),
    .cli_ack    (cli_ack),
    .cli_addr   (cli_addr),
    .cli_data   (cli_data),
    .cli_wr     (cli_wr),
    .cli_rdata  (cli_rdata),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial begin
    clkSYS = 1'b0;
    forever #5 clkSYS = ~clkSYS;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int last_ack();
    return (ack_log.size() > 0) ? ack_log[ack_log.size()-1] : -1;
  endfunction

  // Every bench cycle goes through here: logs acks and models client req drop/re-raise.
  task automatic tick();
    @(negedge clkSYS);
    cyc++;
    if (cli_ack != 4'b0000) begin
      check("ack_onehot", 32'($onehot(cli_ack)), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (cli_ack[i]) begin
          ack_log.push_back(i);
          ack_rd.push_back(cli_rdata);
          ack_cyc.push_back(cyc);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (cli_ack[i]) begin
        cli_req[i] = 1'b0;
        rearm[i]   = rearm_dly;
      end else if (rearm[i] > 0) begin
        rearm[i]--;
        if (rearm[i] == 0) cli_req[i] = 1'b1;
      end
    end
  endtask

  task automatic set_cli(input int i, input logic [23:0] a, input logic [15:0] d, input logic w);
    cli_addr[i*24 +: 24] = a;
    cli_data[i*16 +: 16] = d;
    cli_wr[i]            = w;
    addr_tab[i]          = a;
  endtask

  task automatic serve(input int ack_dly, input int rv_dly, input logic [15:0] rd);
    int  t;
    logic is_wr;
    t = 0;
    while (mem_req !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    if (mem_req !== 1'b1) begin
      check("mem_req_timeout", 32'(mem_req), 32'd1);
      return;
    end
    for (int i = 0; i < ack_dly; i++) tick();
    if (ack_dly > 0) check("mem_req_held", 32'(mem_req), 32'd1);
    obs_addr = mem_addr;
    obs_data = mem_data;
    obs_wr   = mem_wr;
    is_wr    = mem_wr;
    mem_ack  = 1'b1;
    if (!is_wr && rv_dly == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (!is_wr && rv_dly > 0) begin
      for (int i = 0; i < rv_dly - 1; i++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(cli_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    n_reset = 1'b1;
    tick();
  endtask

  int base;
  int exp_c;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    rearm_dly  = 0;
    for (int i = 0; i < 4; i++) rearm[i] = 0;
    n_reset    = 1'b0;
    cli_req    = '0;
    cli_addr   = '0;
    cli_data   = '0;
    cli_wr     = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    tick();
    check("rst_rdata", 32'(cli_rdata), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    do_reset();

    // Single write from client 2, mem_ack two cycles late.
    base = ack_log.size();
    set_cli(2, 24'h000123, 16'hA5A5, 1'b1);
    cli_req[2] = 1'b1;
    serve(2, 0, 16'h0000);
    check("wr_addr", 32'(obs_addr), 32'h000123);
    check("wr_data", 32'(obs_data), 32'hA5A5);
    check("wr_dir", 32'(obs_wr), 32'd1);
    check("wr_ack_vec", 32'(cli_ack), 32'b0100);
    check("wr_mem_req_drop", 32'(mem_req), 32'd0);
    tick();
    check("wr_ack_pulse", 32'(cli_ack), 32'd0);
    tick();
    check("wr_ack_count", 32'(ack_log.size() - base), 32'd1);
    check("wr_idle", 32'(mem_req), 32'd0);

    // Read from client 1, data five cycles after mem_ack.
    base = ack_log.size();
    set_cli(1, 24'h000456, 16'h0000, 1'b0);
    cli_req[1] = 1'b1;
    serve(0, 5, 16'h1234);
    check("rd_addr", 32'(obs_addr), 32'h000456);
    check("rd_dir", 32'(obs_wr), 32'd0);
    check("rd_ack_client", 32'(last_ack()), 32'd1);
    check("rd_rdata", 32'(cli_rdata), 32'h1234);
    tick();
    tick();
    check("rd_ack_count", 32'(ack_log.size() - base), 32'd1);

    // mem_ack and mem_rvalid together on a read.
    base = ack_log.size();
    set_cli(2, 24'h000777, 16'h0000, 1'b0);
    cli_req[2] = 1'b1;
    serve(1, 0, 16'hBEEF);
    check("same_cyc_client", 32'(last_ack()), 32'd2);
    check("same_cyc_rdata", 32'(cli_rdata), 32'hBEEF);
    tick();
    tick();
    check("same_cyc_count", 32'(ack_log.size() - base), 32'd1);

    // All four clients requesting; rotation must start at client 0 after reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_cli(i, 24'h000200 + 24'(i), 16'h1000 + 16'(i), 1'b1);
    rearm_dly = 4;
    base = ack_log.size();
    cli_req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      serve(0, 0, 16'h0000);
      check("rr_count", 32'(ack_log.size() - base), 32'(k + 1));
      check("rr_order", 32'(last_ack()), 32'(k % 4));
      check("rr_addr", 32'(obs_addr), 32'(addr_tab[k % 4]));
    end
    rearm_dly = 0;
    for (int i = 0; i < 4; i++) rearm[i] = 0;
    cli_req = '0;
    tick();
    tick();

    // Client 3 alone, back to back.
    rearm_dly = 1;
    base = ack_log.size();
    cli_req[3] = 1'b1;
    for (int k = 0; k < 3; k++) serve(0, 0, 16'h0000);
    rearm_dly = 0;
    for (int i = 0; i < 4; i++) rearm[i] = 0;
    cli_req = '0;
    for (int i = 0; i < 5; i++) tick();
    check("solo_count", 32'(ack_log.size() - base), 32'd3);
    if (ack_log.size() - base >= 3) begin
      for (int k = 1; k < 3; k++) begin
        check("solo_client", 32'(ack_log[base + k]), 32'd3);
        check("solo_spacing", 32'((ack_cyc[base + k] - ack_cyc[base + k - 1]) >= 3), 32'd1);
      end
    end
    check("solo_no_stale", 32'(mem_req), 32'd0);

    // Reset while waiting for read data; late rvalid must not produce an ack.
    base = ack_log.size();
    set_cli(1, 24'h000999, 16'h0000, 1'b0);
    cli_req[1] = 1'b1;
    exp_c = 0;
    while (mem_req !== 1'b1 && exp_c < 40) begin
      tick();
      exp_c++;
    end
    check("rst_mid_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    n_reset = 1'b0;
    #1;
    check("rst_mid_async_req", 32'(mem_req), 32'd0);
    check("rst_mid_async_addr", 32'(mem_addr), 32'd0);
    tick();
    cli_req[1] = 1'b0;
    n_reset    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();
    check("rst_mid_no_ack", 32'(ack_log.size() - base), 32'd0);
    check("rst_mid_rdata", 32'(cli_rdata), 32'd0);
    check("rst_mid_idle", 32'(mem_req), 32'd0);
    set_cli(0, 24'h0000A0, 16'h0A0A, 1'b1);
    set_cli(3, 24'h0000A3, 16'h0A3A, 1'b1);
    cli_req[0] = 1'b1;
    cli_req[3] = 1'b1;
    serve(0, 0, 16'h0000);
    cli_req[3] = 1'b0;
    check("rst_mid_next_client", 32'(last_ack()), 32'd0);
    check("rst_mid_next_addr", 32'(obs_addr), 32'h0000A0);
    tick();
    tick();

    // Clients 0 and 2 continuously requesting.
    set_cli(0, 24'h000300, 16'h3000, 1'b1);
    set_cli(2, 24'h000302, 16'h3002, 1'b1);
    rearm_dly = 1;
    base = ack_log.size();
    cli_req[0] = 1'b1;
    cli_req[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve(0, 0, 16'h0000);
`ifdef ARB_FIXED_PRIO_EN
      exp_c = 0;
`else
      exp_c = (k % 2 == 0) ? 2 : 0;
`endif
      check("pair_order", 32'(last_ack()), 32'(exp_c));
    end
    rearm_dly = 0;
    for (int i = 0; i < 4; i++) rearm[i] = 0;
    cli_req = '0;
    for (int i = 0; i < 3; i++) tick();
    check("pair_count", 32'(ack_log.size() - base), 32'd6);
    check("final_idle", 32'(mem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Responder end of the arbiter_if request/ack protocol used by display and sampling clients.
- Accepts N client requests, grants one at a time in round-robin order, and forwards the granted transfer to the single memory controller port.
- Returns a one-cycle ack to the granted client, with read data for reads.
- Sits between the display/sample writers and the SDRAM controller, clocked on clkSYS.

Parameters:
N, 4, number of client ports (2..8)
AW, 24, address width
DW, 16, data width

Ports:
clkSYS  in  1  system clock; only clock
n_reset  in  1  asynchronous active-low reset
cli_req  in  N  client request; held high until acked
cli_ack  out  N  one-cycle ack pulse per client
cli_addr  in  N*AW  client address, client i at [i*AW +: AW]
cli_data  in  N*DW  client write data, packed the same way
cli_wr  in  N  1 = write, 0 = read
cli_rdata  out  DW  read data, valid in the cycle cli_ack is high for a read
mem_req  out  1  memory request
mem_ack  in  1  memory accepted request (single-cycle pulse)
mem_addr  out  AW  latched address
mem_data  out  DW  latched write data
mem_wr  out  1  latched direction
mem_rdata  in  DW  memory read data
mem_rvalid  in  1  read data valid (single-cycle pulse)

Behaviour:
- Reset (async, n_reset low) clears:
  - cli_ack, mem_req, mem_addr, mem_data, mem_wr, cli_rdata to 0
  - state to Idle
  - last-grant pointer to N-1, so client 0 has first priority
- States: Idle, Issue, RdWait, Ack.
- Idle:
  - If any cli_req is high, pick g = first requesting index scanning last+1, last+2, ... with mod-N wrap.
  - Latch cli_addr[g], cli_data[g], cli_wr[g] into mem_*; set mem_req=1; set last=g; go to Issue.
  - Latency: req seen at edge k gives mem_req high after edge k.
- Issue:
  - Hold mem_req and mem_* stable until mem_ack.
  - On mem_ack: mem_req<=0.
  - If mem_wr: cli_ack[g]<=1 and go to Ack.
  - If read: go to RdWait.
- RdWait:
  - On mem_rvalid: cli_rdata<=mem_rdata, cli_ack[g]<=1, go to Ack.
  - mem_rvalid in any other state is ignored.
- Ack:
  - cli_ack[g] is high for exactly this one cycle; cli_ack<=0; go to Idle.
  - No request sampling in Ack. The client drops req on the edge where it sees ack, so its stale req is never re-granted.
- cli_ack is one-hot or zero at all times, and is registered (no combinational path from any input).
- mem_ack and mem_rvalid arriving in the same cycle while in Issue with a read:
  - Treat as ack followed by immediate data: go directly to Ack with the data captured.
- Client drops req while granted (protocol violation): the transaction still completes and the ack is still pulsed.
- Fairness: with all N clients requesting continuously, each client is granted once per N transactions.
- Minimum write cycle is 3 clocks: Idle, Issue with mem_ack in the first cycle, Ack.
- Reset mid-transaction: everything aborts immediately. After reset, no ack is issued for the aborted transfer.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: client 0 always wins when it requests; the remaining clients rotate round-robin among themselves. Used for the display refresh reader, which must not underrun.
- Undefined: pure round-robin across all N clients, as above.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {Idle, Issue, RdWait, Ack}
  - default width constants ARB_AW=24, ARB_DW=16
- Sub-module rr_select: combinational rotate-and-priority-encode.
  - Inputs: req[N], last index.
  - Outputs: grant index, any-request flag.
  - Compile-time fixed-priority variant selected under ARB_FIXED_PRIO_EN.
- The top level maps arbiter_if instances onto the packed cli_* vectors.

Test Plan:
- Reset, then single write from client 2 (addr 0x000123, data 0xA5A5), mem_ack 2 cycles after mem_req -> mem_addr=0x000123, mem_wr=1, cli_ack=4'b0100 for exactly 1 cycle, back to Idle.
- Read from client 1, mem_rvalid 5 cycles after mem_ack with mem_rdata=0x1234 -> cli_ack[1] pulses with cli_rdata=0x1234; no other ack.
- All 4 clients hold req (each drops its own on ack, re-raises 4 cycles later) -> grant order 0,1,2,3,0,1,... over 12 transactions; no client acked twice in a row.
- Client 3 alone requesting back-to-back -> no double grant of its stale req; ack spacing ≥3 cycles.
- n_reset asserted while in RdWait, mem_rvalid arrives afterwards -> no cli_ack; mem_req=0; next grant goes to client 0.
- With ARB_FIXED_PRIO_EN, clients 0 and 2 requesting continuously -> client 0 wins every arbitration in which its req is high.
